// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_read_ctrl : async FIFO read-side controller with a one-entry FWFT
//                  output register, empty/almost-empty and occupancy status.
// Revision: 1.0
// ============================================================================
module fifo_read_ctrl #(
   parameter int DATA_SIZE     = 8,
   parameter int ADDR_SIZE     = 4,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic [ADDR_SIZE:0]   wptr,
   input  logic [DATA_SIZE-1:0] mem_rdata,
   input  logic                 rready,
   output logic [ADDR_SIZE-1:0] raddr,
   output logic [ADDR_SIZE:0]   rptr,
   output logic [DATA_SIZE-1:0] rdata,
   output logic                 rvalid,
   output logic                 rempty,
   output logic                 raempty,
   output logic [ADDR_SIZE:0]   rcount
);

   localparam logic [ADDR_SIZE:0] AE_THRESH = AEMPTY_THRESH[ADDR_SIZE:0];

   logic [ADDR_SIZE:0] rq1_wptr;
   logic [ADDR_SIZE:0] rq2_wptr;
   logic [ADDR_SIZE:0] rbin;
   logic [ADDR_SIZE:0] rbin_next;
   logic [ADDR_SIZE:0] rptr_next;
   logic [ADDR_SIZE:0] wbin_s;
   logic [ADDR_SIZE:0] mem_count;
   logic               mem_empty;
   logic               fetch;

   // Plain two-flop synchronizer; nothing may sit between the stages.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rq1_wptr <= '0;
         rq2_wptr <= '0;
      end else begin
         rq1_wptr <= wptr;
         rq2_wptr <= rq1_wptr;
      end
   end

   // Gray compare including the MSB keeps laps apart across wrap-around.
   assign mem_empty = (rptr == rq2_wptr);
   assign fetch     = !mem_empty && (!rvalid || rready);
   assign rbin_next = rbin + {{ADDR_SIZE{1'b0}}, fetch};
   assign rptr_next = rbin_next ^ (rbin_next >> 1);

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin   <= '0;
         rptr   <= '0;
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rbin <= rbin_next;
         rptr <= rptr_next;
         if (fetch) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      wbin_s = '0;
      for (int i = 0; i <= ADDR_SIZE; i++) begin
         wbin_s[i] = ^(rq2_wptr >> i);
      end
   end

   // Words still in memory plus the one parked in the output register.
   assign mem_count = wbin_s - rbin;
   assign rcount    = mem_count + {{ADDR_SIZE{1'b0}}, rvalid};
   assign raempty   = (rcount <= AE_THRESH);
   assign rempty    = !rvalid;
   assign raddr     = rbin[ADDR_SIZE-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// Directed self-checking bench for fifo_read_ctrl (ADDR_SIZE=4, DATA_SIZE=8).
module tb_fifo_read_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] wptr = '0;
   logic [7:0] mem_rdata;
   logic       rready = 1'b0;
   logic [3:0] raddr;
   logic [4:0] rptr;
   logic [7:0] rdata;
   logic       rvalid;
   logic       rempty;
   logic       raempty;
   logic [4:0] rcount;

   logic [7:0] mem [16];
   logic [4:0] wbin = '0;
   int         n_assert = 0;
   int         n_fail   = 0;

   fifo_read_ctrl #(
      .DATA_SIZE(8), .ADDR_SIZE(4), .AEMPTY_THRESH(2)
   ) dut (
      .rclk(clk), .rrst(rst), .wptr(wptr), .mem_rdata(mem_rdata),
      .rready(rready), .raddr(raddr), .rptr(rptr), .rdata(rdata),
      .rvalid(rvalid), .rempty(rempty), .raempty(raempty), .rcount(rcount)
   );

   assign mem_rdata = mem[raddr];

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [7:0] d);
      mem[wbin[3:0]] = d;
      wbin = wbin + 5'd1;
      wptr = wbin ^ (wbin >> 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rvalid"},  32'(rvalid),  32'd1 - 32'd1);
      check({tag, "_rempty"},  32'(rempty),  32'd1);
      check({tag, "_rptr"},    32'(rptr),    32'd0);
      check({tag, "_raddr"},   32'(raddr),   32'd0);
      check({tag, "_rcount"},  32'(rcount),  32'd0);
      check({tag, "_raempty"}, 32'(raempty), 32'd1);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      rready = 1'b0;
      wbin   = '0;
      wptr   = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;

      // Power-on reset state
      tick();
      check_reset_outputs("por");
      check("por_rdata", 32'(rdata), 32'h0);
      rst = 1'b0;
      tick();

      // Single word: visible after the third edge
      write_word(8'hA5);
      tick();
      tick();
      check("single_not_yet", 32'(rvalid), 32'd0);
      tick();
      check("single_rdata",  32'(rdata),  32'hA5);
      check("single_rvalid", 32'(rvalid), 32'd1);
      check("single_raddr",  32'(raddr),  32'd1);
      check("single_rptr",   32'(rptr),   32'b00001);
      check("single_rcount", 32'(rcount), 32'd1);
      tick();
      check("single_hold", 32'(rdata), 32'hA5);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check("single_pop_rempty", 32'(rempty), 32'd1);
      check("single_pop_rcount", 32'(rcount), 32'd0);

      // Stream of 16 words at one per cycle
      do_reset();
      for (int i = 0; i < 16; i++) write_word(8'(i));
      check("stream_wptr", 32'(wptr), 32'b11000);
      rready = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 16; k++) begin
         tick();
         check($sformatf("stream_rdata%0d", k), 32'(rdata), 32'(k));
         check($sformatf("stream_rvalid%0d", k), 32'(rvalid), 32'd1);
         if (k == 0) check("stream_full_rcount", 32'(rcount), 32'd16);
      end
      tick();
      check("stream_end_rptr",   32'(rptr),   32'b11000);
      check("stream_end_rempty", 32'(rempty), 32'd1);
      check("stream_end_rcount", 32'(rcount), 32'd0);
      rready = 1'b0;

      // Backpressure: one fetch only, then hold
      do_reset();
      write_word(8'hB0);
      write_word(8'hB1);
      write_word(8'hB2);
      repeat (5) tick();
      check("bp_rdata",   32'(rdata),   32'hB0);
      check("bp_rvalid",  32'(rvalid),  32'd1);
      check("bp_raddr",   32'(raddr),   32'd1);
      check("bp_rcount",  32'(rcount),  32'd3);
      check("bp_raempty", 32'(raempty), 32'd0);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check("bp_pulse_rdata",   32'(rdata),   32'hB1);
      check("bp_pulse_rcount",  32'(rcount),  32'd2);
      check("bp_pulse_raempty", 32'(raempty), 32'd1);
      tick();
      check("bp_pulse_hold", 32'(rdata), 32'hB1);

      // Wrap: 40 words in batches of 10
      do_reset();
      rready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 10; j++) write_word(8'(8'h40 + b * 10 + j));
         tick();
         tick();
         for (int j = 0; j < 10; j++) begin
            tick();
            check($sformatf("wrap_b%0d_w%0d", b, j), 32'(rdata), 32'(8'h40 + b * 10 + j));
         end
         tick();
         check($sformatf("wrap_b%0d_rempty", b), 32'(rempty), 32'd1);
         check($sformatf("wrap_b%0d_rcount", b), 32'(rcount), 32'd0);
      end
      check("wrap_rptr",  32'(rptr),  32'b01100);
      check("wrap_raddr", 32'(raddr), 32'd8);
      rready = 1'b0;

      // Reset mid-stream with pending words
      do_reset();
      for (int i = 0; i < 5; i++) write_word(8'(8'hC0 + i));
      repeat (3) tick();
      check("mid_pre_rdata", 32'(rdata), 32'hC0);
      #2;
      rst  = 1'b1;
      wbin = '0;
      wptr = '0;
      #1;
      check_reset_outputs("mid");
      check("mid_rdata", 32'(rdata), 32'h0);
      tick();
      rst    = 1'b0;
      rready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("mid_after_rvalid%0d", k), 32'(rvalid), 32'd0);
         check($sformatf("mid_after_rcount%0d", k), 32'(rcount), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the asynchronous FIFO, running in the read clock domain. It pairs with the dual-port FIFO memory and the write-side pointer logic. It synchronizes the Gray-coded write pointer into `rclk`, maintains the binary and Gray read pointers, and drives the memory read address. A one-entry first-word-fall-through output register presents data with a valid/ready handshake, plus empty, almost-empty and occupancy status.

## Interface
Parameters:
- `DATA_SIZE`, 8: data width; must match the memory.
- `ADDR_SIZE`, 4: memory address width. DEPTH = 2^ADDR_SIZE.
- `AEMPTY_THRESH`, 2: `raempty` asserts when `rcount` <= this value.

Ports:
- `rclk`  in  1  read clock. Single clock; every register is in this domain.
- `rrst`  in  1  asynchronous, active-high reset.
- `wptr`  in  ADDR_SIZE+1  Gray write pointer from the write domain. Changes by at most one bit per write.
- `mem_rdata`  in  DATA_SIZE  combinational read data from memory at `raddr`.
- `rready`  in  1  consumer accepts `rdata` this cycle.
- `raddr`  out  ADDR_SIZE  memory read address.
- `rptr`  out  ADDR_SIZE+1  registered Gray read pointer, to the write domain.
- `rdata`  out  DATA_SIZE  registered output word.
- `rvalid`  out  1  `rdata` holds an unconsumed word.
- `rempty`  out  1  equals `!rvalid`.
- `raempty`  out  1  almost-empty flag.
- `rcount`  out  ADDR_SIZE+1  words available to the reader.

## Operation
- **Write-pointer synchronizer:** two-flop chain `rq1_wptr` -> `rq2_wptr` on `rclk`. No logic sits between the two flops.
- **Read pointers:**
  - `rbin` is an (ADDR_SIZE+1)-bit binary counter.
  - `raddr` = `rbin[ADDR_SIZE-1:0]`.
  - `rptr` is registered as `rbin_next ^ (rbin_next >> 1)`, so `rptr` is always Gray of the current `rbin`.
- **Memory empty:** `mem_empty` = (`rptr` == `rq2_wptr`), a Gray compare that includes the MSB.
- **Fetch condition:** fetch = `!mem_empty && (!rvalid || rready)`.
- **On fetch:**
  - `rdata` <= `mem_rdata`
  - `rvalid` <= 1
  - `rbin` <= `rbin` + 1, wrapping modulo 2^(ADDR_SIZE+1).
- **Pop without fetch:** if `rvalid && rready` and there is no fetch, `rvalid` <= 0 and `rdata` holds its value.
- **Simultaneous pop and fetch:** `rvalid` stays 1 and `rdata` takes the next word. This sustains one word per cycle.
- **`rready` while `rvalid` = 0:** ignored.
- **Occupancy:**
  - `wbin_s` = Gray-to-binary of `rq2_wptr`, computed combinationally.
  - `rcount` = (`wbin_s` - `rbin`) mod 2^(ADDR_SIZE+1), plus `rvalid`.
  - Maximum `rcount` is DEPTH+1: a full memory plus the output register.
- **Almost-empty:** `raempty` = (`rcount` <= `AEMPTY_THRESH`), combinational from registers.
- **Wrap-around:** `rbin` passes from all-ones to 0. The Gray compare stays correct because the MSB distinguishes laps.
- **Reset mid-operation:** all state clears immediately and in-flight data is discarded. The write side must be reset in the same event.

## Timing
- **Reset values:** `rq1_wptr`, `rq2_wptr`, `rbin`, `rptr`, `rdata` = 0 and `rvalid` = 0. Therefore:
  - `raddr` = 0
  - `rempty` = 1
  - `rcount` = 0
  - `raempty` = 1
- **Write-to-read latency:** a `wptr` change is seen in `rq2_wptr` after 2 `rclk` edges. If `rvalid` was 0, the fetch occurs on the 3rd edge and `rvalid` is visible after it.
- **Throughput:** one word per `rclk` while data is available and `rready` = 1.
- **Pointer update:** `rptr` updates on the same edge as the fetch. The writer sees freed space 2 of its own clocks later, through its own synchronizer.
- **Memory read path:** `mem_rdata` is sampled on the same edge that advances `raddr`. The address to data path is combinational within one cycle.

## Test plan
All scenarios use ADDR_SIZE = 4 and DATA_SIZE = 8.
- **Reset:** assert `rrst` mid-cycle -> immediately `rvalid` = 0, `rempty` = 1, `rptr` = 5'b00000, `raddr` = 0, `rcount` = 0, `raempty` = 1.
- **Single word:** mem[0] = 8'hA5; `wptr` 0 -> 5'b00001 -> on edge 3, `rdata` = 8'hA5, `rvalid` = 1, `raddr` = 1, `rptr` = 5'b00001, `rcount` = 1.
- **Stream:** mem[i] = i for 16 words, `wptr` = 5'b11000, `rready` = 1 -> 8'h00..8'h0F in order, one per cycle. Afterwards `rptr` = 5'b11000, `rempty` = 1, `rcount` = 0.
- **Backpressure:** 3 words written, `rready` = 0 -> exactly one fetch, then `rdata` holds, `rbin` = 1, `rcount` = 3, `raempty` = 0. Then pulse `rready` for 1 cycle -> next word appears and `rcount` = 2, `raempty` = 1.
- **Wrap:** 40 words written and read in batches of 10 -> all data in order, `rbin` wraps past 31 to 0, and `rempty` is correct at each batch end.
- **Reset mid-stream:** `rrst` pulse with 5 words pending -> all outputs return to reset values within the same cycle, and no stale word appears after release.
